// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg
//   Shared types for the GEMM issue controller: sub-op encodings, the
//   command record carried through the command FIFO, and the issue FSM
//   state encoding.
//   No ports (package).
package gemm_ctrl_pkg;

   localparam int unsigned GEMM_DATA_W = 32;

   typedef enum logic [2:0] {
      GEMM_RUN  = 3'b000,
      GEMM_SYNC = 3'b111
   } gemm_func_e;

   typedef struct packed {
      logic [GEMM_DATA_W-1:0] rs1;
      logic [GEMM_DATA_W-1:0] rs2;
   } gemm_cmd_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } issue_state_e;

endpackage

// File: rtl/gemm_issue_ctrl_if.sv
// gemm_issue_ctrl_if
//   Command port between the issue controller and the systolic-array engine.
//   Ports:
//     cmd_valid  command offered by the controller
//     cmd_ready  engine accepts the command
//     cmd_rs1    command operand A/B base address
//     cmd_rs2    command operand C base address / dimension word
//     gemm_done  single-cycle pulse: in-flight command finished
//   Modports: master = controller side, slave = engine side.
interface gemm_issue_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_rs1;
   logic [DATA_W-1:0] cmd_rs2;
   logic              gemm_done;

   modport master (
      output cmd_valid, cmd_rs1, cmd_rs2,
      input  cmd_ready, gemm_done
   );

   modport slave (
      input  cmd_valid, cmd_rs1, cmd_rs2,
      output cmd_ready, gemm_done
   );
endinterface

// File: rtl/gemm_cmd_fifo.sv
// gemm_cmd_fifo
//   Synchronous command FIFO, asynchronous active-low reset.
//   Pointers are log2(DEPTH) bits and wrap naturally; count carries one
//   extra bit so that full and empty are distinguishable.
//   Ports:
//     clk, rst         clock, asynchronous active-low reset
//     push, push_data  write request and entry (ignored when full)
//     pop              read request (ignored when empty)
//     head             entry at the read pointer
//     count            number of stored entries
//     full, empty      status flags from the registered count
module gemm_cmd_fifo
   import gemm_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = gemm_cmd_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned       PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage is reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl
//   Issue controller for the GEMM accelerator. Buffers decoded GEMM_RUN
//   operands in a command FIFO, issues one command at a time to the
//   systolic-array engine and retires it on gemm_done. Stalls the core on
//   a full FIFO or while GEMM_SYNC waits for outstanding work to drain.
//   Configuration macro: GEMM_PERF_CNT_EN (saturating perf counters;
//   when undefined both perf outputs are tied to zero).
//   Ports:
//     clk, rst          core clock, asynchronous active-low reset
//     gemm_valid        GEMM instruction in execute (already flush-gated)
//     gemm_func3        sub-op: GEMM_RUN, GEMM_SYNC, others illegal
//     gemm_rs1/rs2      instruction operands
//     stall             combinational stall request to the core
//     cmd_if            engine command port (master side)
//     busy              FIFO non-empty or command in flight
//     illegal_op        high while an illegal func3 is presented
//     perf_busy_cycles  busy-cycle counter
//     perf_cmd_count    completed-command counter
module gemm_issue_ctrl
   import gemm_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     gemm_valid,
   input  logic [2:0]               gemm_func3,
   input  logic [DATA_W-1:0]        gemm_rs1,
   input  logic [DATA_W-1:0]        gemm_rs2,
   output logic                     stall,
   gemm_issue_ctrl_if.master        cmd_if,
   output logic                     busy,
   output logic                     illegal_op,
   output logic [31:0]              perf_busy_cycles,
   output logic [31:0]              perf_cmd_count
);

   typedef struct packed {
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
   } cmd_t;

   issue_state_e                  state;
   cmd_t                          push_data;
   cmd_t                          head;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          is_run;
   logic                          is_sync;
   logic                          push;
   logic                          pop;

   assign is_run     = gemm_valid & (gemm_func3 == GEMM_RUN);
   assign is_sync    = gemm_valid & (gemm_func3 == GEMM_SYNC);
   assign illegal_op = gemm_valid & (gemm_func3 != GEMM_RUN) & (gemm_func3 != GEMM_SYNC);

   // Fullness comes from the registered count only: a same-cycle pop does
   // not free a slot for the incoming RUN, which keeps cmd_ready out of stall.
   assign push  = is_run & ~fifo_full;
   assign busy  = (fifo_count != '0) | (state == WAIT);
   assign stall = (is_run & fifo_full) | (is_sync & busy);

   assign push_data.rs1 = gemm_rs1;
   assign push_data.rs2 = gemm_rs2;

   assign cmd_if.cmd_valid = (state == IDLE) & ~fifo_empty;
   assign cmd_if.cmd_rs1   = head.rs1;
   assign cmd_if.cmd_rs2   = head.rs2;
   assign pop              = cmd_if.cmd_valid & cmd_if.cmd_ready;

   gemm_cmd_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (cmd_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // gemm_done outside WAIT is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (pop)              state <= WAIT;
            WAIT:    if (cmd_if.gemm_done) state <= IDLE;
            default:                       state <= IDLE;
         endcase
      end
   end

`ifdef GEMM_PERF_CNT_EN
   logic [31:0] busy_cycles_q;
   logic [31:0] cmd_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cycles_q <= '0;
         cmd_count_q   <= '0;
      end else begin
         if (busy && (busy_cycles_q != '1)) begin
            busy_cycles_q <= busy_cycles_q + 32'd1;
         end
         if ((state == WAIT) && cmd_if.gemm_done && (cmd_count_q != '1)) begin
            cmd_count_q <= cmd_count_q + 32'd1;
         end
      end
   end

   assign perf_busy_cycles = busy_cycles_q;
   assign perf_cmd_count   = cmd_count_q;
`else
   assign perf_busy_cycles = '0;
   assign perf_cmd_count   = '0;
`endif

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// tb_gemm_issue_ctrl
//   Self-checking bench for gemm_issue_ctrl: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   queue-based behavioural model of the controller.
module tb_gemm_issue_ctrl;
   import gemm_ctrl_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gemm_valid = 1'b0;
   logic [2:0]  gemm_func3 = 3'b000;
   logic [31:0] gemm_rs1 = '0;
   logic [31:0] gemm_rs2 = '0;
   logic        stall;
   logic        busy;
   logic        illegal_op;
   logic [31:0] perf_busy_cycles;
   logic [31:0] perf_cmd_count;

   gemm_issue_ctrl_if #(.DATA_W(32)) cmd_if ();

   gemm_issue_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .DATA_W     (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .gemm_valid       (gemm_valid),
      .gemm_func3       (gemm_func3),
      .gemm_rs1         (gemm_rs1),
      .gemm_rs2         (gemm_rs2),
      .stall            (stall),
      .cmd_if           (cmd_if),
      .busy             (busy),
      .illegal_op       (illegal_op),
      .perf_busy_cycles (perf_busy_cycles),
      .perf_cmd_count   (perf_cmd_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } op_t;

   op_t         mq[$];
   bit          m_inflight = 1'b0;
   logic [31:0] m_busy_cyc = '0;
   logic [31:0] m_cmd_cnt  = '0;
   logic [31:0] dut_issued[$];

   function automatic bit m_busy();
      return (mq.size() != 0) || m_inflight;
   endfunction

   function automatic bit m_valid();
      return !m_inflight && (mq.size() != 0);
   endfunction

   function automatic bit m_stall();
      return gemm_valid &&
             (((gemm_func3 == 3'b000) && (mq.size() == int'(DEPTH))) ||
              ((gemm_func3 == 3'b111) && m_busy()));
   endfunction

   function automatic bit m_illegal();
      return gemm_valid && (gemm_func3 != 3'b000) && (gemm_func3 != 3'b111);
   endfunction

   always @(posedge clk or negedge rst) begin
      bit  was_busy;
      bit  do_pop;
      bit  do_done;
      bit  do_push;
      op_t nop;
      if (!rst) begin
         mq.delete();
         m_inflight = 1'b0;
         m_busy_cyc = '0;
         m_cmd_cnt  = '0;
      end else begin
         was_busy = m_busy();
         do_pop   = m_valid() && cmd_if.cmd_ready;
         do_done  = m_inflight && cmd_if.gemm_done;
         do_push  = gemm_valid && (gemm_func3 == 3'b000) && (mq.size() < int'(DEPTH));
`ifdef GEMM_PERF_CNT_EN
         if (was_busy && (m_busy_cyc != 32'hFFFF_FFFF)) m_busy_cyc = m_busy_cyc + 32'd1;
         if (do_done && (m_cmd_cnt != 32'hFFFF_FFFF))   m_cmd_cnt  = m_cmd_cnt + 32'd1;
`endif
         if (do_pop) begin
            void'(mq.pop_front());
            m_inflight = 1'b1;
         end
         if (do_done) m_inflight = 1'b0;
         if (do_push) begin
            nop.rs1 = gemm_rs1;
            nop.rs2 = gemm_rs2;
            mq.push_back(nop);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      #2;
      if (rst) begin
         chk("stall",      32'(stall),            32'(m_stall()));
         chk("illegal_op", 32'(illegal_op),       32'(m_illegal()));
         chk("busy",       32'(busy),             32'(m_busy()));
         chk("cmd_valid",  32'(cmd_if.cmd_valid), 32'(m_valid()));
         if (m_valid()) begin
            chk("cmd_rs1", cmd_if.cmd_rs1, mq[0].rs1);
            chk("cmd_rs2", cmd_if.cmd_rs2, mq[0].rs2);
         end
         chk("perf_busy_cycles", perf_busy_cycles, m_busy_cyc);
         chk("perf_cmd_count",   perf_cmd_count,   m_cmd_cnt);
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) dut_issued.push_back(cmd_if.cmd_rs2);
      end
   end

   // ---------------- stimulus ----------------
   // Applies inputs at negedge+1 and returns at negedge+3 of the same cycle.
   task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic rdy, input logic dn);
      @(negedge clk);
      #1;
      gemm_valid       = v;
      gemm_func3       = f;
      gemm_rs1         = a;
      gemm_rs2         = b;
      cmd_if.cmd_ready = rdy;
      cmd_if.gemm_done = dn;
      #2;
   endtask

   task automatic idle(input logic rdy, input logic dn);
      drive(1'b0, 3'b000, '0, '0, rdy, dn);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_stall"},      32'(stall),            32'd0);
      chk({tag, "_cmd_valid"},  32'(cmd_if.cmd_valid), 32'd0);
      chk({tag, "_busy"},       32'(busy),             32'd0);
      chk({tag, "_illegal"},    32'(illegal_op),       32'd0);
      chk({tag, "_cmd_rs1"},    cmd_if.cmd_rs1,        32'd0);
      chk({tag, "_cmd_rs2"},    cmd_if.cmd_rs2,        32'd0);
      chk({tag, "_perf_busy"},  perf_busy_cycles,      32'd0);
      chk({tag, "_perf_cmd"},   perf_cmd_count,        32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        hv;
      logic [2:0]  hf;
      logic [31:0] ha;
      logic [31:0] hb;
      bit          held;
      int unsigned r;

      cmd_if.cmd_ready = 1'b0;
      cmd_if.gemm_done = 1'b0;
      #12;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Single RUN
      drive(1'b1, 3'b000, 32'h1000, 32'h0008, 1'b1, 1'b0);
      chk("run_stall", 32'(stall), 32'd0);
      chk("run_valid_before", 32'(cmd_if.cmd_valid), 32'd0);
      idle(1'b1, 1'b0);
      chk("run_valid", 32'(cmd_if.cmd_valid), 32'd1);
      chk("run_rs1", cmd_if.cmd_rs1, 32'h1000);
      chk("run_rs2", cmd_if.cmd_rs2, 32'h0008);
      idle(1'b1, 1'b0);
      chk("run_wait_valid", 32'(cmd_if.cmd_valid), 32'd0);
      chk("run_wait_busy", 32'(busy), 32'd1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      chk("run_done_busy", 32'(busy), 32'd0);

      // Illegal op
      drive(1'b1, 3'b010, 32'h77, 32'h77, 1'b0, 1'b0);
      chk("ill_pulse", 32'(illegal_op), 32'd1);
      chk("ill_stall", 32'(stall), 32'd0);
      idle(1'b0, 1'b0);
      chk("ill_after", 32'(illegal_op), 32'd0);
      chk("ill_busy", 32'(busy), 32'd0);

      // Backpressure with a spurious done in IDLE
      drive(1'b1, 3'b000, 32'hABC0, 32'h55, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("bp_valid", 32'(cmd_if.cmd_valid), 32'd1);
      chk("bp_rs1_a", cmd_if.cmd_rs1, 32'hABC0);
      idle(1'b0, 1'b1);
      chk("bp_rs1_b", cmd_if.cmd_rs1, 32'hABC0);
      chk("bp_rs2_b", cmd_if.cmd_rs2, 32'h55);
      idle(1'b0, 1'b0);
      chk("bp_spurious_valid", 32'(cmd_if.cmd_valid), 32'd1);
      chk("bp_rs1_c", cmd_if.cmd_rs1, 32'hABC0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      chk("bp_wait_valid", 32'(cmd_if.cmd_valid), 32'd0);
      chk("bp_wait_busy", 32'(busy), 32'd1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      chk("bp_one_pop", 32'(busy), 32'd0);

      // FIFO full, then in-order drain
      dut_issued.delete();
      for (int i = 1; i <= 5; i++) drive(1'b1, 3'b000, 32'(i) << 4, 32'(i), 1'b0, 1'b0);
      chk("full_stall", 32'(stall), 32'd1);
      drive(1'b1, 3'b000, 32'h50, 32'd5, 1'b1, 1'b0);
      chk("full_stall_pop", 32'(stall), 32'd1);
      drive(1'b1, 3'b000, 32'h50, 32'd5, 1'b0, 1'b0);
      chk("full_accept", 32'(stall), 32'd0);
      for (int k = 0; k < 12; k++) idle(1'b1, 1'b1);
      idle(1'b0, 1'b0);
      chk("full_drained", 32'(busy), 32'd0);
      chk("full_issue_cnt", 32'(dut_issued.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < dut_issued.size()) chk("full_order", dut_issued[i], 32'(i + 1));
      end

      // SYNC drain
      drive(1'b1, 3'b000, 32'hA0, 32'hA, 1'b1, 1'b0);
      drive(1'b1, 3'b000, 32'hB0, 32'hB, 1'b1, 1'b0);
      drive(1'b1, 3'b111, '0, '0, 1'b1, 1'b0);
      chk("sync_stall_1", 32'(stall), 32'd1);
      drive(1'b1, 3'b111, '0, '0, 1'b1, 1'b1);
      chk("sync_stall_2", 32'(stall), 32'd1);
      drive(1'b1, 3'b111, '0, '0, 1'b1, 1'b0);
      chk("sync_stall_3", 32'(stall), 32'd1);
      drive(1'b1, 3'b111, '0, '0, 1'b0, 1'b1);
      chk("sync_stall_4", 32'(stall), 32'd1);
      drive(1'b1, 3'b111, '0, '0, 1'b0, 1'b0);
      chk("sync_release", 32'(stall), 32'd0);
      chk("sync_busy", 32'(busy), 32'd0);
      idle(1'b0, 1'b0);

      // Reset mid-operation: WAIT with two entries queued
      drive(1'b1, 3'b000, 32'h1, 32'h1, 1'b1, 1'b0);
      drive(1'b1, 3'b000, 32'h2, 32'h2, 1'b1, 1'b0);
      drive(1'b1, 3'b000, 32'h3, 32'h3, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk_zero_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b1;

      // Perf counters: 3 commands, 10 busy cycles
      drive(1'b1, 3'b000, 32'hC1, 32'h1, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b1);
      drive(1'b1, 3'b000, 32'hC2, 32'h2, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b1);
      drive(1'b1, 3'b000, 32'hC3, 32'h3, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
`ifdef GEMM_PERF_CNT_EN
      chk("perf_busy_lit", perf_busy_cycles, 32'd10);
      chk("perf_cmd_lit",  perf_cmd_count,   32'd3);
`else
      chk("perf_busy_lit", perf_busy_cycles, 32'd0);
      chk("perf_cmd_lit",  perf_cmd_count,   32'd0);
`endif

      // Randomized traffic; a stalled instruction is held by the core
      held = 1'b0;
      hv = 1'b0; hf = 3'b000; ha = '0; hb = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!held) begin
            hv = ($urandom_range(0, 9) < 6);
            r  = $urandom_range(0, 9);
            if (r < 6)      hf = 3'b000;
            else if (r < 8) hf = 3'b111;
            else            hf = 3'($urandom_range(1, 6));
            ha = $urandom;
            hb = $urandom;
         end
         drive(hv, hf, ha, hb, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
         held = m_stall();
      end
      for (int k = 0; k < 20; k++) idle(1'b1, 1'b1);
      idle(1'b0, 1'b0);
      chk("final_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
